alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream stage of the 8-bit ALU. Captures each ALU result, its carry_out and zero flags, and the opcode that produced it into a DEPTH-entry first-word-fall-through FIFO with valid/ready on both sides. The FIFO decouples the ALU from a slower consumer such as a register writeback or a UART dump. It also keeps saturating statistics counters of zero-flag and carry-flag results for lab observation.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
PTR_W, 2, pointer width; must equal log2(DEPTH).
CNT_W, 8, width of each statistics counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous FIFO clear
clr_stats  input  1  synchronous statistics clear
in_valid  input  1  ALU result valid
in_ready  output  1  FIFO can accept an entry
in_result  input  8  ALU result
in_carry  input  1  ALU carry_out
in_zero  input  1  ALU zero flag
in_opcode  input  4  opcode that produced the result
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts the head entry
out_result  output  8  head result
out_carry  output  1  head carry
out_zero  output  1  head zero flag
out_opcode  output  4  head opcode
count  output  PTR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
zero_cnt  output  CNT_W  accepted entries with in_zero=1
carry_cnt  output  CNT_W  accepted entries with in_carry=1

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count, zero_cnt and carry_cnt clear to 0.
  - empty=1, full=0, out_valid=0, in_ready=1.
  - Storage array is not reset.
  - Reset mid-operation discards all entries. No output toggles until the first accepted write after rst_n deasserts.
- Entry width is 14 bits: {opcode[3:0], carry, zero, result[7:0]}.
- Output and status decoding:
  - in_ready = !full && !flush. Combinational from registered state and flush only; it never depends on in_valid or out_ready.
  - out_valid = !empty.
  - out_* present the head entry combinationally (first-word fall-through). All out_* are forced to 0 while empty.
- Transfers:
  - Write when in_valid && in_ready. The entry is stored at wr_ptr and wr_ptr increments modulo DEPTH.
  - Read when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Latency: a write accepted at edge N gives out_valid=1 and valid out_* in the cycle after edge N. There is no same-cycle bypass when empty.
- Simultaneous write and read (neither full nor empty): both happen and count is unchanged.
- When full: in_ready=0, so no write is accepted even if a read occurs that cycle. The freed slot becomes writable the next cycle.
- When empty: out_ready is ignored and no read occurs.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0. Order is strictly FIFO across the wrap.
- flush:
  - At the next edge, pointers and count go to 0 and empty=1.
  - Writes and reads in the flush cycle are discarded/ignored.
  - Statistics are unaffected.
- Statistics:
  - On an accepted write, zero_cnt increments if in_zero=1 and carry_cnt increments if in_carry=1.
  - Each counter saturates at 2^CNT_W-1.
  - clr_stats clears both counters at the next edge. If it coincides with an accepted write, the clear wins and the counters become 0.
  - Writes discarded by flush or blocked by full do not count.
- The block does not check flag consistency (e.g. zero vs result); it stores whatever is presented.

Test Plan:
- Reset, then write {result=8'h2A, carry=0, zero=0, opcode=4'h0} for 1 cycle with out_ready=0 -> next cycle out_valid=1, out_result=8'h2A, count=1, empty=0, zero_cnt=0.
- Write 4 entries (results 8'h01..8'h04) with out_ready=0 -> full=1, in_ready=0, count=4. A 5th in_valid with result 8'h05 is not accepted. Then drain with out_ready=1 -> out_result sequence 01,02,03,04, then empty=1 and out_* = 0.
- Hold in_valid=1 and out_ready=1 continuously for 10 cycles with results 8'h10..8'h19 -> count stays 1 after the first write, all 10 values emerge in order across the pointer wrap, none lost.
- With the FIFO full, assert in_valid and out_ready in the same cycle -> head is popped, count=3, new entry not accepted. Next cycle the write is accepted and count=4.
- Write 3 entries with zero=1 and carry=1, then assert flush and clr_stats together with another in_valid -> count=0, empty=1, zero_cnt=0, carry_cnt=0, flushed-cycle entry absent.
- Write 300 entries with in_zero=1 and CNT_W=8 -> zero_cnt saturates at 255. Assert rst_n=0 asynchronously mid-stream -> all counters and count are 0 immediately, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for ALU results with
// saturating zero/carry statistics counters.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic [3:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [3:0]       out_opcode,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [13:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [13:0]      head;
    logic             wr_en;
    logic             rd_en;

    assign full      = count == FULL_CNT;
    assign empty     = count == '0;
    assign in_ready  = !full && !flush;
    assign out_valid = !empty;
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready && !flush;
    // Outputs are held at zero while empty so stale storage never leaks out.
    assign head      = empty ? '0 : mem[rd_ptr];
    assign {out_opcode, out_carry, out_zero, out_result} = head;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_opcode, in_carry, in_zero, in_result};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt  <= '0;
            carry_cnt <= '0;
        end else if (clr_stats) begin
            zero_cnt  <= '0;
            carry_cnt <= '0;
        end else if (wr_en) begin
            if (in_zero && zero_cnt != '1) zero_cnt <= zero_cnt + CNT_W'(1);
            if (in_carry && carry_cnt != '1) carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench; a reference queue tracks accepted
// entries and every cycle the DUT state is compared against it.
module tb_alu_result_fifo;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 8;

    logic clk = 0;
    logic rst_n = 0;
    logic flush = 0;
    logic clr_stats = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [7:0] in_result = 0;
    logic in_carry = 0;
    logic in_zero = 0;
    logic [3:0] in_opcode = 0;
    logic out_valid;
    logic out_ready = 0;
    logic [7:0] out_result;
    logic out_carry;
    logic out_zero;
    logic [3:0] out_opcode;
    logic [PTR_W:0] count;
    logic full;
    logic empty;
    logic [CNT_W-1:0] zero_cnt;
    logic [CNT_W-1:0] carry_cnt;

    alu_result_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_carry(in_carry), .in_zero(in_zero), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_opcode(out_opcode),
        .count(count), .full(full), .empty(empty),
        .zero_cnt(zero_cnt), .carry_cnt(carry_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [13:0] q[$];
    int zm = 0;
    int cm = 0;
    localparam int SAT = (1 << CNT_W) - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare against the model state, then advance the model by the
    // handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        logic wr;
        logic rd;
        if (!rst_n) begin
            q.delete();
            zm = 0;
            cm = 0;
        end else begin
            check("in_ready", in_ready, (q.size() < DEPTH) && !flush);
            check("out_valid", out_valid, q.size() != 0);
            check("count", count, q.size());
            check("full_empty", {full, empty}, {q.size() == DEPTH, q.size() == 0});
            check("zero_cnt", zero_cnt, zm);
            check("carry_cnt", carry_cnt, cm);
            if (q.size() == 0)
                check("idle_out", {out_opcode, out_carry, out_zero, out_result}, 0);
            else
                check("head", {out_opcode, out_carry, out_zero, out_result}, q[0]);
            wr = in_valid && !flush && q.size() < DEPTH;
            rd = out_ready && !flush && q.size() != 0;
            if (flush) q.delete();
            else begin
                if (rd) begin
                    void'(q.pop_front());
                    n_pop++;
                end
                if (wr) q.push_back({in_opcode, in_carry, in_zero, in_result});
            end
            if (clr_stats) begin
                zm = 0;
                cm = 0;
            end else if (wr) begin
                if (in_zero && zm < SAT) zm++;
                if (in_carry && cm < SAT) cm++;
            end
        end
    end

    task automatic drive(input logic iv, input logic [7:0] r, input logic c, input logic z,
                         input logic [3:0] op, input logic ordy);
        in_valid = iv;
        in_result = r;
        in_carry = c;
        in_zero = z;
        in_opcode = op;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_flags", {empty, full, out_valid, in_ready}, 4'b1001);
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0);

        drive(1, 8'h2A, 0, 0, 4'h0, 0);
        check("t1_result", out_result, 8'h2A);
        check("t1_count", count, 1);
        check("t1_zero_cnt", zero_cnt, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        for (int i = 1; i <= 4; i++) drive(1, 8'(i), 0, 0, 4'h1, 0);
        check("t2_full", {full, in_ready, count}, {1'b1, 1'b0, 3'd4});
        drive(1, 8'h05, 0, 0, 4'h1, 0);
        check("t2_blocked", count, 4);
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain", out_result, 8'(i));
            drive(0, 0, 0, 0, 0, 1);
        end
        check("t2_empty", {empty, out_result}, {1'b1, 8'h00});

        p0 = n_pop;
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h10 + 8'(i), i[0], 0, 4'(i), 1);
            check("t3_count", count, 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        check("t3_pops", n_pop - p0, 10);

        for (int i = 0; i < 4; i++) drive(1, 8'h40 + 8'(i), 1, 0, 4'h3, 0);
        drive(1, 8'h55, 0, 1, 4'h7, 1);
        check("t4_pop_no_push", count, 3);
        drive(1, 8'h55, 0, 1, 4'h7, 0);
        check("t4_push", count, 4);
        repeat (5) drive(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) drive(1, 8'h00, 1, 1, 4'h2, 0);
        flush = 1;
        clr_stats = 1;
        drive(1, 8'hEE, 1, 1, 4'h9, 1);
        flush = 0;
        clr_stats = 0;
        check("t5_flush", {empty, count}, {1'b1, 3'd0});
        check("t5_stats", {zero_cnt, carry_cnt}, 0);
        drive(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) drive(1, 8'(i), 0, 1, 4'h5, 1);
        check("t6_sat", zero_cnt, 255);
        drive(1, 8'hAB, 1, 1, 4'h5, 0);
        #2;
        rst_n = 0;
        #1;
        check("t6_arst_cnt", {zero_cnt, carry_cnt, count}, 0);
        check("t6_arst_flags", {out_valid, in_ready}, 2'b01);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 8'h77, 1, 0, 4'hC, 0);
        check("t6_after", {out_opcode, out_carry, out_zero, out_result}, {4'hC, 1'b1, 1'b0, 8'h77});
        repeat (2) drive(0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
